// File: rtl/mbyte_add_seq.sv
// Byte-serial multi-precision adder: streams NBYTES-wide operands LSB byte first
// through one 8-bit ripple adder, carrying between bytes in a register.

module ebaUfa (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_fa
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[8];
endmodule

module mbyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_first,
    output logic       out_last,
    output logic       out_cout,
    output logic       out_ovf
);
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] byte_cnt_reg, byte_cnt_next;
    logic          carry_reg, carry_next;
    logic          valid_reg, valid_next;
    logic [7:0]    sum_reg, sum_next;
    logic          first_reg, first_next;
    logic          last_reg, last_next;
    logic          cout_reg, cout_next;
    logic          ovf_reg, ovf_next;

    logic       accept;
    logic       last_byte;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;

    // Single output stage: a pop frees the slot for a push in the same cycle.
    assign in_ready  = ~valid_reg | out_ready;
    assign accept    = in_valid & in_ready;
    assign last_byte = (byte_cnt_reg == CW'(NBYTES - 1));
    assign add_cin   = (state_reg == IDLE) ? in_cin : carry_reg;

    ebaUfa u_add (
        .a    (in_a),
        .b    (in_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        carry_next    = carry_reg;
        valid_next    = valid_reg;
        sum_next      = sum_reg;
        first_next    = first_reg;
        last_next     = last_reg;
        cout_next     = cout_reg;
        ovf_next      = ovf_reg;

        if (accept) begin
            carry_next = add_cout;
            valid_next = 1'b1;
            sum_next   = add_sum;
            first_next = (byte_cnt_reg == '0);
            last_next  = last_byte;
            cout_next  = 1'b0;
            ovf_next   = 1'b0;
            if (last_byte) begin
                byte_cnt_next = '0;
                state_next    = IDLE;
                cout_next     = add_cout;
                ovf_next      = (in_a[7] == in_b[7]) & (add_sum[7] != in_a[7]);
            end else begin
                byte_cnt_next = byte_cnt_reg + 1'b1;
                state_next    = RUN;
            end
        end else if (out_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            carry_reg    <= 1'b0;
            valid_reg    <= 1'b0;
            sum_reg      <= 8'h00;
            first_reg    <= 1'b0;
            last_reg     <= 1'b0;
            cout_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            carry_reg    <= carry_next;
            valid_reg    <= valid_next;
            sum_reg      <= sum_next;
            first_reg    <= first_next;
            last_reg     <= last_next;
            cout_reg     <= cout_next;
            ovf_reg      <= ovf_next;
        end
    end

    assign out_valid = valid_reg;
    assign out_sum   = sum_reg;
    assign out_first = first_reg;
    assign out_last  = last_reg;
    assign out_cout  = cout_reg;
    assign out_ovf   = ovf_reg;
endmodule
